// File: rtl/mem_requester_if.sv
// Command, response and bus-control signals between a CPU-side requester and
// its memory controller. The shared tristate data bus stays a plain port.
interface mem_requester_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rw;
  logic [AWIDTH-1:0] cmd_addr;
  logic [DWIDTH-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DWIDTH-1:0] rsp_rdata;
  logic              rsp_err;
  logic              bus_valid;
  logic              bus_rw;
  logic [AWIDTH-1:0] bus_addr;
  logic              bus_ready;

  modport master (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, bus_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, bus_valid, bus_rw, bus_addr
  );

  modport slave (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, bus_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, bus_valid, bus_rw, bus_addr
  );
endinterface

// File: rtl/mem_requester.sv
// CPU-side bus initiator: one command at a time, Ready low->high completion.
// Optional watchdog enabled by defining MEM_REQ_TIMEOUT_EN.
module mem_requester #(
  parameter int DWIDTH     = 32,
  parameter int AWIDTH     = 16,
  parameter int TMO_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_requester_if.master   mif,
  inout  wire  [DWIDTH-1:0] bus_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              accept_s;
  logic              complete_s;
  logic              expire_s;
  logic              tmo_s;
  logic              bus_valid_r;
  logic              bus_rw_r;
  logic [AWIDTH-1:0] bus_addr_r;
  logic [DWIDTH-1:0] wdata_r;
  logic              rsp_valid_r;
  logic [DWIDTH-1:0] rsp_rdata_r;
  logic              rsp_err_r;

  if (TMO_CYCLES < 1) begin : g_tmo_chk
    $error("mem_requester: TMO_CYCLES must be at least 1");
  end

`ifdef MEM_REQ_TIMEOUT_EN
  localparam int CW = $clog2(TMO_CYCLES + 1);
  logic [CW-1:0] tmo_cnt_r;

  // Cycles spent waiting on the responder for the current command.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_r <= {CW{1'b0}};
    end else if (accept_s) begin
      tmo_cnt_r <= {CW{1'b0}};
    end else if ((state_r == REQ) || (state_r == BUSY)) begin
      tmo_cnt_r <= tmo_cnt_r + CW'(1'b1);
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  // Fires on the edge at which the count would reach TMO_CYCLES.
  assign tmo_s = ((state_r == REQ) || (state_r == BUSY)) &&
                 (tmo_cnt_r == CW'(TMO_CYCLES - 1));
`else
  assign tmo_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and per-edge strobes; a Ready completion beats a same-edge timeout.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    complete_s  = 1'b0;
    expire_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (mif.cmd_valid) begin
          accept_s    = 1'b1;
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (tmo_s) begin
          expire_s    = 1'b1;
          state_nxt_s = DONE;
        end else if (!mif.bus_ready) begin
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = REQ;
        end
      end
      BUSY: begin
        if (mif.bus_ready) begin
          complete_s  = 1'b1;
          state_nxt_s = DONE;
        end else if (tmo_s) begin
          expire_s    = 1'b1;
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Bus request, latched write data and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_valid_r <= 1'b0;
      bus_rw_r    <= 1'b1;
      bus_addr_r  <= {AWIDTH{1'b0}};
      wdata_r     <= {DWIDTH{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DWIDTH{1'b0}};
      rsp_err_r   <= 1'b0;
    end else begin
      rsp_valid_r <= 1'b0;
      if (accept_s) begin
        bus_valid_r <= 1'b1;
        bus_rw_r    <= mif.cmd_rw;
        bus_addr_r  <= mif.cmd_addr;
        wdata_r     <= mif.cmd_wdata;
      end else if (complete_s) begin
        bus_valid_r <= 1'b0;
        rsp_valid_r <= 1'b1;
        rsp_err_r   <= 1'b0;
        if (bus_rw_r) begin
          rsp_rdata_r <= bus_data;
        end
      end else if (expire_s) begin
        bus_valid_r <= 1'b0;
        rsp_valid_r <= 1'b1;
        rsp_err_r   <= 1'b1;
      end else if (state_r == DONE) begin
        bus_rw_r <= 1'b1;
      end
    end
  end

  assign mif.cmd_ready = rst_n && (state_r == IDLE);
  assign mif.bus_valid = bus_valid_r;
  assign mif.bus_rw    = bus_rw_r;
  assign mif.bus_addr  = bus_addr_r;
  assign mif.rsp_valid = rsp_valid_r;
  assign mif.rsp_rdata = rsp_rdata_r;
  assign mif.rsp_err   = rsp_err_r;

  // Only a pending write owns the shared data bus.
  assign bus_data = (bus_valid_r && !bus_rw_r) ? wdata_r : {DWIDTH{1'bz}};

endmodule

// File: tb/tb_mem_requester.sv
// Directed bench for mem_requester with a behavioural responder; bus_data is
// pulled high so an undriven bus reads as all ones.
module tb_mem_requester;
  logic clk = 1'b0;
  logic rst_n;
  logic rd_drv;
  logic [31:0] rd_val;
  tri1  [31:0] bus_data;
  int chk_cnt = 0;
  int pass_cnt = 0;

  mem_requester_if #(.DWIDTH(32), .AWIDTH(16)) mif ();

  mem_requester #(.DWIDTH(32), .AWIDTH(16), .TMO_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .mif(mif), .bus_data(bus_data)
  );

  assign bus_data = rd_drv ? rd_val : 32'hzzzz_zzzz;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mif.cmd_valid = 1'b1; mif.cmd_rw = 1'b0;
    mif.cmd_addr = 16'h0abc; mif.cmd_wdata = 32'h5555_5555;
    tick(); tick();
    chk_cnt++; if (mif.cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready: got %b exp 0", mif.cmd_ready); else pass_cnt++;
    chk_cnt++; if (mif.bus_valid !== 1'b0) $display("FAIL reset_bus_valid: got %b exp 0", mif.bus_valid); else pass_cnt++;
    chk_cnt++; if (bus_data !== 32'hffff_ffff) $display("FAIL reset_bus_data_released: got %h exp ffffffff", bus_data); else pass_cnt++;
    chk_cnt++; if (mif.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b exp 0", mif.rsp_valid); else pass_cnt++;
    chk_cnt++; if (mif.rsp_rdata !== 32'h0) $display("FAIL reset_rsp_rdata: got %h exp 0", mif.rsp_rdata); else pass_cnt++;
    chk_cnt++; if (mif.bus_rw !== 1'b1 || mif.bus_addr !== 16'h0) $display("FAIL reset_bus_rw_addr: got %b/%h exp 1/0000", mif.bus_rw, mif.bus_addr); else pass_cnt++;
    mif.cmd_valid = 1'b0; rst_n = 1'b1;
    tick();
    chk_cnt++; if (mif.cmd_ready !== 1'b1 || mif.bus_valid !== 1'b0) $display("FAIL reset_release_idle: got ready=%b valid=%b exp 1/0", mif.cmd_ready, mif.bus_valid); else pass_cnt++;
  endtask

  task automatic test_write();
    int pulses = 0;
    bit stable_ok = 1'b1;
    mif.cmd_valid = 1'b1; mif.cmd_rw = 1'b0; mif.cmd_addr = 16'h0012; mif.cmd_wdata = 32'hDEAD_BEEF;
    tick();
    mif.cmd_valid = 1'b0; mif.cmd_wdata = 32'h0;
    chk_cnt++; if (mif.cmd_ready !== 1'b0) $display("FAIL wr_cmd_ready_busy: got %b exp 0", mif.cmd_ready); else pass_cnt++;
    mif.bus_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (mif.bus_valid !== 1'b1 || mif.bus_rw !== 1'b0 || mif.bus_addr !== 16'h0012 || bus_data !== 32'hDEAD_BEEF) stable_ok = 1'b0;
      if (mif.rsp_valid === 1'b1) pulses++;
      if (i < 4) tick();
    end
    mif.bus_ready = 1'b1;
    tick();
    chk_cnt++; if (mif.rsp_valid !== 1'b1) $display("FAIL wr_rsp_valid: got %b exp 1", mif.rsp_valid); else pass_cnt++;
    chk_cnt++; if (mif.rsp_err !== 1'b0) $display("FAIL wr_rsp_err: got %b exp 0", mif.rsp_err); else pass_cnt++;
    chk_cnt++; if (mif.bus_valid !== 1'b0) $display("FAIL wr_bus_valid_drop: got %b exp 0", mif.bus_valid); else pass_cnt++;
    if (mif.rsp_valid === 1'b1) pulses++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mif.rsp_valid === 1'b1) pulses++;
    end
    chk_cnt++; if (!stable_ok) $display("FAIL wr_bus_stable: got unstable bus exp rw=0 addr=0012 data=deadbeef"); else pass_cnt++;
    chk_cnt++; if (pulses != 1) $display("FAIL wr_rsp_pulse_count: got %0d exp 1", pulses); else pass_cnt++;
    chk_cnt++; if (bus_data !== 32'hffff_ffff || mif.bus_rw !== 1'b1) $display("FAIL wr_bus_release: got data=%h rw=%b exp ffffffff/1", bus_data, mif.bus_rw); else pass_cnt++;
    chk_cnt++; if (mif.rsp_rdata !== 32'h0) $display("FAIL wr_rdata_untouched: got %h exp 0", mif.rsp_rdata); else pass_cnt++;
    chk_cnt++; if (mif.cmd_ready !== 1'b1) $display("FAIL wr_back_to_idle: got %b exp 1", mif.cmd_ready); else pass_cnt++;
  endtask

  task automatic test_read();
    mif.cmd_valid = 1'b1; mif.cmd_rw = 1'b1; mif.cmd_addr = 16'h00FF; mif.cmd_wdata = 32'h0;
    tick();
    mif.cmd_valid = 1'b0;
    chk_cnt++; if (mif.bus_rw !== 1'b1 || mif.bus_addr !== 16'h00FF) $display("FAIL rd_bus_cmd: got rw=%b addr=%h exp 1/00ff", mif.bus_rw, mif.bus_addr); else pass_cnt++;
    chk_cnt++; if (bus_data !== 32'hffff_ffff) $display("FAIL rd_no_drive_req: got %h exp ffffffff", bus_data); else pass_cnt++;
    tick(); tick();
    chk_cnt++; if (mif.rsp_valid !== 1'b0 || mif.bus_valid !== 1'b1) $display("FAIL rd_ready_high_in_req: got rsp=%b valid=%b exp 0/1", mif.rsp_valid, mif.bus_valid); else pass_cnt++;
    mif.bus_ready = 1'b0;
    tick();
    chk_cnt++; if (bus_data !== 32'hffff_ffff) $display("FAIL rd_no_drive_busy: got %h exp ffffffff", bus_data); else pass_cnt++;
    tick();
    mif.bus_ready = 1'b1; rd_drv = 1'b1; rd_val = 32'h1234_5678;
    tick();
    chk_cnt++; if (mif.rsp_valid !== 1'b1) $display("FAIL rd_rsp_valid: got %b exp 1", mif.rsp_valid); else pass_cnt++;
    chk_cnt++; if (mif.rsp_rdata !== 32'h1234_5678) $display("FAIL rd_rsp_rdata: got %h exp 12345678", mif.rsp_rdata); else pass_cnt++;
    rd_drv = 1'b0;
    tick();
    chk_cnt++; if (mif.rsp_valid !== 1'b0 || mif.rsp_rdata !== 32'h1234_5678) $display("FAIL rd_rdata_hold: got rsp=%b rdata=%h exp 0/12345678", mif.rsp_valid, mif.rsp_rdata); else pass_cnt++;
    chk_cnt++; if (mif.cmd_ready !== 1'b1) $display("FAIL rd_back_to_idle: got %b exp 1", mif.cmd_ready); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    int acc_cyc [2] = '{0, 0};
    int rsp_n = 0;
    int rsp_at_acc2 = -1;
    int vcnt = 0;
    int low_run = 0;
    int gap = 0;
    bit prev_valid = 1'b0;
    bit wr_ok = 1'b1;
    bit will_accept;
    logic [31:0] rdata_after_wr = 32'h0;
    mif.cmd_valid = 1'b1; mif.cmd_rw = 1'b0; mif.cmd_addr = 16'h0034; mif.cmd_wdata = 32'hCAFE_F00D;
    for (int cyc = 0; cyc < 40 && rsp_n < 2; cyc++) begin
      will_accept = mif.cmd_ready && mif.cmd_valid;
      tick();
      if (will_accept) begin
        if (acc < 2) acc_cyc[acc] = cyc;
        if (acc == 1) rsp_at_acc2 = rsp_n;
        acc++;
        if (acc == 1) begin
          mif.cmd_rw = 1'b1; mif.cmd_addr = 16'h0056; mif.cmd_wdata = 32'h0;
        end else begin
          mif.cmd_valid = 1'b0;
        end
      end
      if (mif.rsp_valid === 1'b1) begin
        rsp_n++;
        if (rsp_n == 1) rdata_after_wr = mif.rsp_rdata;
      end
      if (mif.bus_valid === 1'b1) begin
        if (!prev_valid && acc == 2) gap = low_run;
        low_run = 0; vcnt++;
      end else begin
        low_run++; vcnt = 0;
      end
      prev_valid = (mif.bus_valid === 1'b1);
      if (mif.bus_valid === 1'b1 && mif.bus_rw === 1'b0 && bus_data !== 32'hCAFE_F00D) wr_ok = 1'b0;
      mif.bus_ready = !(vcnt >= 1 && vcnt <= 3);
      rd_drv = (vcnt >= 4) && (mif.bus_rw === 1'b1);
      rd_val = 32'hA5A5_A5A5;
    end
    mif.cmd_valid = 1'b0; rd_drv = 1'b0; mif.bus_ready = 1'b1;
    chk_cnt++; if (rsp_n != 2 || acc != 2) $display("FAIL b2b_counts: got rsp=%0d acc=%0d exp 2/2", rsp_n, acc); else pass_cnt++;
    chk_cnt++; if (rsp_at_acc2 != 1) $display("FAIL b2b_second_after_done: got %0d responses before 2nd accept exp 1", rsp_at_acc2); else pass_cnt++;
    chk_cnt++; if (gap < 1) $display("FAIL b2b_valid_gap: got %0d exp >=1", gap); else pass_cnt++;
    chk_cnt++; if (acc_cyc[1] - acc_cyc[0] < 4) $display("FAIL b2b_accept_interval: got %0d exp >=4", acc_cyc[1] - acc_cyc[0]); else pass_cnt++;
    chk_cnt++; if (!wr_ok) $display("FAIL b2b_write_data: got bad bus_data exp cafef00d"); else pass_cnt++;
    chk_cnt++; if (rdata_after_wr !== 32'h1234_5678) $display("FAIL b2b_write_keeps_rdata: got %h exp 12345678", rdata_after_wr); else pass_cnt++;
    chk_cnt++; if (mif.rsp_rdata !== 32'hA5A5_A5A5) $display("FAIL b2b_read_data: got %h exp a5a5a5a5", mif.rsp_rdata); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid_busy();
    int pulses = 0;
    mif.cmd_valid = 1'b1; mif.cmd_rw = 1'b0; mif.cmd_addr = 16'h0042; mif.cmd_wdata = 32'h0BAD_F00D;
    tick();
    mif.cmd_valid = 1'b0; mif.bus_ready = 1'b0;
    tick(); tick();
    chk_cnt++; if (mif.bus_valid !== 1'b1 || bus_data !== 32'h0BAD_F00D) $display("FAIL mid_pre_reset: got valid=%b data=%h exp 1/0badf00d", mif.bus_valid, bus_data); else pass_cnt++;
    rst_n = 1'b0;
    tick();
    chk_cnt++; if (mif.bus_valid !== 1'b0 || bus_data !== 32'hffff_ffff) $display("FAIL mid_bus_release: got valid=%b data=%h exp 0/ffffffff", mif.bus_valid, bus_data); else pass_cnt++;
    chk_cnt++; if (mif.rsp_valid !== 1'b0 || mif.cmd_ready !== 1'b0) $display("FAIL mid_rsp_ready: got rsp=%b ready=%b exp 0/0", mif.rsp_valid, mif.cmd_ready); else pass_cnt++;
    chk_cnt++; if (mif.rsp_rdata !== 32'h0) $display("FAIL mid_rdata_cleared: got %h exp 0", mif.rsp_rdata); else pass_cnt++;
    rst_n = 1'b1; mif.bus_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mif.rsp_valid === 1'b1) pulses++;
    end
    chk_cnt++; if (pulses != 0 || mif.cmd_ready !== 1'b1) $display("FAIL mid_no_rsp: got pulses=%0d ready=%b exp 0/1", pulses, mif.cmd_ready); else pass_cnt++;
    mif.cmd_valid = 1'b1; mif.cmd_rw = 1'b1; mif.cmd_addr = 16'h0099;
    tick();
    mif.cmd_valid = 1'b0;
    chk_cnt++; if (mif.bus_valid !== 1'b1 || mif.bus_addr !== 16'h0099) $display("FAIL mid_post_accept: got valid=%b addr=%h exp 1/0099", mif.bus_valid, mif.bus_addr); else pass_cnt++;
    mif.bus_ready = 1'b0;
    tick();
    mif.bus_ready = 1'b1; rd_drv = 1'b1; rd_val = 32'h600D_CAFE;
    tick();
    chk_cnt++; if (mif.rsp_valid !== 1'b1 || mif.rsp_rdata !== 32'h600D_CAFE) $display("FAIL mid_post_read: got rsp=%b rdata=%h exp 1/600dcafe", mif.rsp_valid, mif.rsp_rdata); else pass_cnt++;
    rd_drv = 1'b0;
    tick();
  endtask

`ifdef MEM_REQ_TIMEOUT_EN
  task automatic test_timeout();
    int early = 0;
    mif.cmd_valid = 1'b1; mif.cmd_rw = 1'b1; mif.cmd_addr = 16'h0001; mif.bus_ready = 1'b1;
    tick();
    mif.cmd_valid = 1'b0;
    for (int k = 1; k < 16; k++) begin
      tick();
      if (mif.rsp_valid === 1'b1) early++;
    end
    tick();
    chk_cnt++; if (early != 0) $display("FAIL tmo_early: got %0d early pulses exp 0", early); else pass_cnt++;
    chk_cnt++; if (mif.rsp_valid !== 1'b1 || mif.rsp_err !== 1'b1) $display("FAIL tmo_rsp: got rsp=%b err=%b exp 1/1", mif.rsp_valid, mif.rsp_err); else pass_cnt++;
    chk_cnt++; if (mif.bus_valid !== 1'b0 || mif.rsp_rdata !== 32'h600D_CAFE) $display("FAIL tmo_bus: got valid=%b rdata=%h exp 0/600dcafe", mif.bus_valid, mif.rsp_rdata); else pass_cnt++;
    tick();
    chk_cnt++; if (mif.cmd_ready !== 1'b1 || mif.rsp_valid !== 1'b0) $display("FAIL tmo_idle: got ready=%b rsp=%b exp 1/0", mif.cmd_ready, mif.rsp_valid); else pass_cnt++;
  endtask
`endif

  initial begin
    rst_n = 1'b0; rd_drv = 1'b0; rd_val = 32'h0;
    mif.cmd_valid = 1'b0; mif.cmd_rw = 1'b0; mif.cmd_addr = 16'h0; mif.cmd_wdata = 32'h0;
    mif.bus_ready = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid_busy();
`ifdef MEM_REQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation time limit exp completion");
    $fatal(1, "watchdog expired");
  end
endmodule
